vga_timing_monitor: RTL and testbench
=====================================

// Module: vga_timing_monitor
// PURPOSE
//   Sink-side checker for the VGA pixel stream (hs/vs/de/rgb) produced by the video generator.
//   Measures line/frame timing and locks once timing is stable. Recovers active-pixel coordinates.
//   Produces a per-frame pixel checksum for self-test of the display path.
//   Sits on the generator outputs, in parallel with the physical VGA/HDMI transmitter.
// PARAMETERS
//   LOCK_FRAMES  2  consecutive identical frame measurements required to assert locked (1..15)
//   HS_POL       0  sync-active level of vga_hs (0 = active low)
//   VS_POL       0  sync-active level of vga_vs (0 = active low)
// PORTS
//   clk            in   1   pixel clock, same clock as the generator
//   reset_n        in   1   asynchronous active-low reset
//   vga_hs         in   1   horizontal sync
//   vga_vs         in   1   vertical sync
//   vga_de         in   1   data enable, active high
//   vga_r/g/b      in   8   pixel colour, each channel
//   meas_h_total   out  12  clocks per line (hs-start to hs-start period)
//   meas_h_active  out  12  de-high clocks per line
//   meas_v_total   out  12  lines per frame (hs starts between vs starts)
//   meas_v_active  out  12  lines per frame containing >=1 de-high clock
//   locked         out  1   timing stable; pixel outputs trustworthy
//   pix_valid      out  1   registered de
//   pix_x, pix_y   out  12  active-area coordinates of the current pixel
//   pix_rgb        out  24  {r,g,b} delayed to align with pix_valid
//   frame_sum      out  24  sum mod 2^24 of {r,g,b} over all de-high pixels of the last frame
//   sum_valid      out  1   one-cycle pulse when frame_sum updates
//   err_count      out  8   lock-loss events, saturates at 255
// BEHAVIOUR
//   - Reset: all outputs 0; FSM in SEARCH; all internal counters 0.
//   - Input stage: hs/vs/de/rgb registered once (_q). Sync start = transition to active level on _q.
//     pix_* and sum outputs lag the inputs by 2 clk.
//   - Counters are 12-bit and saturate at 4095; a saturated counter forces a measurement mismatch.
//   - Line: h_cnt clears on hs start, else increments. Period = h_cnt+1 at hs start.
//     h_active latches the de-high count at hs start.
//   - Frame: v_cnt counts hs starts; it latches and clears on vs start.
//     v_active counts lines with de seen; it latches and clears on vs start.
//   - hs start and vs start on the same clk: the hs edge is counted in the ending frame, then v_cnt clears.
//   - FSM (transitions evaluated at vs start):
//       SEARCH  -> MEASURE at first vs start.
//       MEASURE -> CHECK: latch meas_*; match_cnt=1.
//       CHECK:  frame equals meas_* -> match_cnt++;
//               match_cnt reaches LOCK_FRAMES -> LOCKED, locked=1.
//               mismatch -> reload meas_*, match_cnt=1.
//       LOCKED: line period != meas_h_total at any hs start, or frame mismatch at vs start
//               -> SEARCH, locked=0 on the next clk, err_count++ (saturating).
//   - meas_* outputs update only on MEASURE/CHECK latches and hold in LOCKED.
//   - pix_x: 0 on the first de-high clk of a line, +1 per de-high clk.
//   - pix_y: 0 for the first active line after vs start, +1 per subsequent line containing de.
//   - pix_valid/pix_x/pix_y/pix_rgb update every clk regardless of lock.
//   - frame_sum: accumulator adds {r,g,b} on each de-high clk.
//     At vs start: frame_sum <= acc (including any pixel on that same clk), acc clears, sum_valid pulses.
//     No sum_valid pulse at the first vs start after reset or after SEARCH.
//   - Reset asserted mid-frame: immediate return to reset state; relock requires LOCK_FRAMES+1 vs starts.
// TESTING
//   1 Generator h_total=99, h_sync=10, h_start=20, h_end=84, v_total=49, v_start=5, v_end=37:
//     -> meas_h_total=100, meas_h_active=64, meas_v_total=50, meas_v_active=32;
//        locked rises on the 3rd vs start after reset.
//   2 Locked, one line stretched to 101 clk
//     -> locked=0 the clk after that hs start; err_count=1; relock after 3 further vs starts.
//   3 Constant rgb 0x000001 over a 64x32 active area -> frame_sum=0x000800 with a sum_valid pulse each frame.
//     rgb 0xFFFFFF -> frame_sum=0xFFF800 (mod 2^24).
//   4 First/last active pixel -> pix_x=0/63 and pix_y=0/31; pix_valid matches vga_de delayed 2 clk.
//   5 hs held inactive for 5000 clk -> h_cnt saturates at 4095; no lock;
//     err_count increments only if LOCKED was held beforehand.
//   6 reset_n pulsed low mid-frame while locked -> all outputs 0 asynchronously; SEARCH on release.

Source files
------------

// File: rtl/vga_timing_monitor.sv
// Sink-side VGA stream checker: measures line/frame timing, locks on stable timing,
// recovers active-pixel coordinates and produces a per-frame {r,g,b} checksum.
module vga_timing_monitor #(
    parameter int LOCK_FRAMES = 2,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic        vga_de,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    output logic [11:0] meas_h_total,
    output logic [11:0] meas_h_active,
    output logic [11:0] meas_v_total,
    output logic [11:0] meas_v_active,
    output logic        locked,
    output logic        pix_valid,
    output logic [11:0] pix_x,
    output logic [11:0] pix_y,
    output logic [23:0] pix_rgb,
    output logic [23:0] frame_sum,
    output logic        sum_valid,
    output logic [7:0]  err_count
);

    typedef enum logic [1:0] {SEARCH, MEASURE, CHECK, LOCKED} state_e;

    localparam logic [4:0] LOCK_N = 5'(LOCK_FRAMES);

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (&v) ? v : v + 12'd1;
    endfunction

    // Input stage: sync levels are stored as "active" flags so polarity is resolved once.
    logic        hs_q, hs_prev_q, vs_q, vs_prev_q, de_q;
    logic [23:0] rgb_q;

    logic [11:0] h_cnt_q, h_cnt_d;
    logic [11:0] x_cnt_q, x_cnt_d;
    logic [11:0] v_cnt_q, v_cnt_d;
    logic [11:0] y_next_q, y_next_d;
    logic [11:0] y_cur_q, y_cur_d;
    logic        line_de_q, line_de_d;
    logic [11:0] cur_h_total_q, cur_h_active_q;
    logic        bad_q;
    logic [23:0] acc_q;

    logic        pix_valid_q;
    logic [11:0] pix_x_q, pix_y_q;
    logic [23:0] pix_rgb_q, frame_sum_q;
    logic        sum_valid_q;

    state_e      state_q;
    logic [3:0]  match_q;
    logic        locked_q;
    logic [7:0]  err_q;
    logic [11:0] m_h_total_q, m_h_active_q, m_v_total_q, m_v_active_q;

    logic        hs_start, vs_start, first_px, line_de_base, sat_now, frame_bad;
    logic        frame_match, line_bad;
    logic [11:0] line_period, x_base, y_next_base, v_cnt_inc;
    logic [11:0] h_tot_now, h_act_now;
    logic [23:0] acc_now;
    logic [4:0]  match_inc;

    always_comb begin
        hs_start     = hs_q & ~hs_prev_q;
        vs_start     = vs_q & ~vs_prev_q;
        line_period  = h_cnt_q + 12'd1;
        h_cnt_d      = hs_start ? 12'd0 : sat_inc(h_cnt_q);

        x_base       = hs_start ? 12'd0 : x_cnt_q;
        x_cnt_d      = de_q ? sat_inc(x_base) : x_base;

        // y_next counts lines that have shown de since vs start; it is both pix_y's
        // source and the v_active measurement.
        line_de_base = hs_start ? 1'b0 : line_de_q;
        y_next_base  = vs_start ? 12'd0 : y_next_q;
        first_px     = de_q & ~line_de_base;
        y_cur_d      = first_px ? y_next_base : y_cur_q;
        y_next_d     = first_px ? sat_inc(y_next_base) : y_next_base;
        line_de_d    = line_de_base | de_q;

        // An hs start coinciding with vs start belongs to the frame that is ending.
        v_cnt_inc    = hs_start ? sat_inc(v_cnt_q) : v_cnt_q;
        v_cnt_d      = vs_start ? 12'd0 : v_cnt_inc;

        sat_now      = (&h_cnt_q) | (&x_cnt_q) | (&v_cnt_q) | (&y_next_q);
        frame_bad    = bad_q | sat_now;

        // h_active tracks the last line that carried pixels, so trailing blank lines don't zero it.
        h_tot_now    = hs_start ? line_period : cur_h_total_q;
        h_act_now    = (hs_start && x_cnt_q != 12'd0) ? x_cnt_q : cur_h_active_q;

        frame_match  = !frame_bad && h_tot_now == m_h_total_q && h_act_now == m_h_active_q
                       && v_cnt_inc == m_v_total_q && y_next_q == m_v_active_q;
        line_bad     = (&h_cnt_q) | (hs_start && line_period != m_h_total_q);

        acc_now      = acc_q + (de_q ? rgb_q : 24'd0);
        match_inc    = {1'b0, match_q} + 5'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_q           <= 1'b0;
            hs_prev_q      <= 1'b0;
            vs_q           <= 1'b0;
            vs_prev_q      <= 1'b0;
            de_q           <= 1'b0;
            rgb_q          <= '0;
            h_cnt_q        <= '0;
            x_cnt_q        <= '0;
            v_cnt_q        <= '0;
            y_next_q       <= '0;
            y_cur_q        <= '0;
            line_de_q      <= 1'b0;
            cur_h_total_q  <= '0;
            cur_h_active_q <= '0;
            bad_q          <= 1'b0;
            acc_q          <= '0;
            pix_valid_q    <= 1'b0;
            pix_x_q        <= '0;
            pix_y_q        <= '0;
            pix_rgb_q      <= '0;
            frame_sum_q    <= '0;
            sum_valid_q    <= 1'b0;
        end else begin
            hs_q      <= (vga_hs == HS_POL);
            hs_prev_q <= hs_q;
            vs_q      <= (vga_vs == VS_POL);
            vs_prev_q <= vs_q;
            de_q      <= vga_de;
            rgb_q     <= {vga_r, vga_g, vga_b};

            h_cnt_q   <= h_cnt_d;
            x_cnt_q   <= x_cnt_d;
            v_cnt_q   <= v_cnt_d;
            y_next_q  <= y_next_d;
            y_cur_q   <= y_cur_d;
            line_de_q <= line_de_d;
            bad_q     <= vs_start ? 1'b0 : frame_bad;
            if (hs_start) cur_h_total_q <= line_period;
            if (hs_start && x_cnt_q != 12'd0) cur_h_active_q <= x_cnt_q;

            pix_valid_q <= de_q;
            pix_rgb_q   <= rgb_q;
            pix_y_q     <= y_cur_d;
            if (de_q) pix_x_q <= x_base;

            sum_valid_q <= 1'b0;
            if (vs_start) begin
                acc_q <= '0;
                if (state_q != SEARCH) begin
                    frame_sum_q <= acc_now;
                    sum_valid_q <= 1'b1;
                end
            end else begin
                acc_q <= acc_now;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= SEARCH;
            match_q      <= '0;
            locked_q     <= 1'b0;
            err_q        <= '0;
            m_h_total_q  <= '0;
            m_h_active_q <= '0;
            m_v_total_q  <= '0;
            m_v_active_q <= '0;
        end else begin
            case (state_q)
                SEARCH: if (vs_start) state_q <= MEASURE;
                MEASURE: if (vs_start) begin
                    m_h_total_q  <= h_tot_now;
                    m_h_active_q <= h_act_now;
                    m_v_total_q  <= v_cnt_inc;
                    m_v_active_q <= y_next_q;
                    match_q      <= 4'd1;
                    if (LOCK_FRAMES <= 1) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                    end else begin
                        state_q  <= CHECK;
                    end
                end
                CHECK: if (vs_start) begin
                    if (frame_match) begin
                        match_q <= match_inc[3:0];
                        if (match_inc >= LOCK_N) begin
                            state_q  <= LOCKED;
                            locked_q <= 1'b1;
                        end
                    end else begin
                        m_h_total_q  <= h_tot_now;
                        m_h_active_q <= h_act_now;
                        m_v_total_q  <= v_cnt_inc;
                        m_v_active_q <= y_next_q;
                        match_q      <= 4'd1;
                    end
                end
                LOCKED: if (line_bad || (vs_start && !frame_match)) begin
                    state_q  <= SEARCH;
                    locked_q <= 1'b0;
                    match_q  <= '0;
                    if (err_q != 8'hFF) err_q <= err_q + 8'd1;
                end
                default: state_q <= SEARCH;
            endcase
        end
    end

    assign meas_h_total  = m_h_total_q;
    assign meas_h_active = m_h_active_q;
    assign meas_v_total  = m_v_total_q;
    assign meas_v_active = m_v_active_q;
    assign locked        = locked_q;
    assign err_count     = err_q;
    assign pix_valid     = pix_valid_q;
    assign pix_x         = pix_x_q;
    assign pix_y         = pix_y_q;
    assign pix_rgb       = pix_rgb_q;
    assign frame_sum     = frame_sum_q;
    assign sum_valid     = sum_valid_q;

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench: a 100x50 VGA generator drives the monitor; expectations are hand-derived.
module tb_vga_timing_monitor;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vga_hs, vga_vs, vga_de;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic [11:0] meas_h_total, meas_h_active, meas_v_total, meas_v_active;
    logic        locked, pix_valid, sum_valid;
    logic [11:0] pix_x, pix_y;
    logic [23:0] pix_rgb, frame_sum;
    logic [7:0]  err_count;

    always #5 clk = ~clk;

    vga_timing_monitor dut (
        .clk(clk), .reset_n(reset_n),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .meas_h_total(meas_h_total), .meas_h_active(meas_h_active),
        .meas_v_total(meas_v_total), .meas_v_active(meas_v_active),
        .locked(locked), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_rgb(pix_rgb), .frame_sum(frame_sum), .sum_valid(sum_valid),
        .err_count(err_count)
    );

    int n_chk = 0;
    int n_fail = 0;

    // generator: h_total=99, h_sync=10, de h 20..83, v_total=49, v_sync=2, de v 5..36
    int          gh, gv, stretch_line, dv;
    bit          idle, pix_mode, drove_hs, drove_vs;
    logic [23:0] rgb_val;
    logic        de_h[3];
    int          hx_h[3], vy_h[3];
    logic [23:0] rgb_h[3];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        logic        de_n;
        logic [23:0] rgb_n;
        @(negedge clk);
        for (int i = 2; i > 0; i--) begin
            de_h[i] = de_h[i-1]; hx_h[i] = hx_h[i-1]; vy_h[i] = vy_h[i-1]; rgb_h[i] = rgb_h[i-1];
        end
        if (idle) begin
            vga_hs = 1'b1; vga_vs = 1'b1; de_n = 1'b0; rgb_n = '0;
            drove_hs = 1'b0; drove_vs = 1'b0;
        end else begin
            de_n  = (gh >= 20 && gh < 84 && gv >= 5 && gv < 37);
            rgb_n = !de_n ? 24'hABCDEF : pix_mode ? {gv[7:0], gh[7:0], 8'h5A} : rgb_val;
            vga_hs = (gh >= 10);
            vga_vs = (gv >= 2);
            drove_hs = (gh == 0);
            drove_vs = (gh == 0 && gv == 0);
            dv = gv;
            hx_h[0] = gh; vy_h[0] = gv;
            if (gh == ((gv == stretch_line) ? 100 : 99)) begin
                gh = 0;
                if (gv == stretch_line) stretch_line = -1;
                gv = (gv == 49) ? 0 : gv + 1;
            end else begin
                gh++;
            end
        end
        vga_de = de_n;
        {vga_r, vga_g, vga_b} = rgb_n;
        de_h[0] = de_n; rgb_h[0] = rgb_n;
    endtask

    task automatic wait_vs();
        int n = 0;
        do begin step(); n++; end while (!drove_vs && n < 6000);
        if (!drove_vs) chk("vs_timeout", 0, 1);
    endtask

    // After wait_vs: one step shows the input stage, the second shows the vs-start update.
    task automatic vs_settle();
        step(); step();
    endtask

    initial begin
        int errs, n;
        logic [11:0] fx, fy, lx, ly;
        reset_n = 1'b0; idle = 1'b1; pix_mode = 1'b0; rgb_val = 24'h000001;
        gh = 0; gv = 0; stretch_line = -1; dv = 0;
        vga_hs = 1'b1; vga_vs = 1'b1; vga_de = 1'b0; {vga_r, vga_g, vga_b} = '0;
        for (int i = 0; i < 3; i++) begin de_h[i] = 0; hx_h[i] = 0; vy_h[i] = 0; rgb_h[i] = 0; end
        repeat (3) @(negedge clk);
        chk("rst_outs_zero", 32'(|{meas_h_total, meas_h_active, meas_v_total, meas_v_active,
            locked, pix_valid, pix_x, pix_y, pix_rgb, frame_sum, sum_valid, err_count}), 0);
        reset_n = 1'b1;

        // idle from SEARCH: counters saturate, no lock, no error
        repeat (5000) step();
        chk("idle_search_locked", 32'(locked), 0);
        chk("idle_search_err", 32'(err_count), 0);
        idle = 1'b0;

        // lock acquisition and measurements
        wait_vs(); vs_settle();
        chk("vs1_no_sum_valid", 32'(sum_valid), 0);
        chk("vs1_locked", 32'(locked), 0);
        wait_vs(); vs_settle();
        chk("vs2_sum_valid", 32'(sum_valid), 1);
        chk("vs2_frame_sum", 32'(frame_sum), 32'h000800);
        chk("meas_h_total", 32'(meas_h_total), 100);
        chk("meas_h_active", 32'(meas_h_active), 64);
        chk("meas_v_total", 32'(meas_v_total), 50);
        chk("meas_v_active", 32'(meas_v_active), 32);
        chk("vs2_locked", 32'(locked), 0);
        wait_vs(); step();
        chk("vs3_pre_locked", 32'(locked), 0);
        step();
        chk("vs3_locked", 32'(locked), 1);

        // checksum wrap with full-white pixels
        rgb_val = 24'hFFFFFF;
        wait_vs(); step();
        chk("vs4_pre_sum_valid", 32'(sum_valid), 0);
        step();
        chk("vs4_sum_valid", 32'(sum_valid), 1);
        chk("vs4_frame_sum", 32'(frame_sum), 32'hFFF800);

        // pixel stream: valid/x/y/rgb against generator delayed two clocks
        pix_mode = 1'b1; errs = 0; n = 0;
        fx = '1; fy = '1; lx = '1; ly = '1;
        do begin
            step(); n++;
            if (pix_valid !== de_h[2]) errs++;
            if (de_h[2]) begin
                if (pix_x !== 12'(hx_h[2] - 20) || pix_y !== 12'(vy_h[2] - 5) || pix_rgb !== rgb_h[2])
                    errs++;
                if (hx_h[2] == 20 && vy_h[2] == 5) begin fx = pix_x; fy = pix_y; end
                if (hx_h[2] == 83 && vy_h[2] == 36) begin lx = pix_x; ly = pix_y; end
            end
        end while (!drove_vs && n < 6000);
        pix_mode = 1'b0;
        chk("pix_stream_errs", 32'(errs), 0);
        chk("pix_first_x", 32'(fx), 0);
        chk("pix_first_y", 32'(fy), 0);
        chk("pix_last_x", 32'(lx), 63);
        chk("pix_last_y", 32'(ly), 31);
        vs_settle();
        chk("vs5_locked", 32'(locked), 1);
        chk("vs5_sum_valid", 32'(sum_valid), 1);

        // one line stretched to 101 clocks
        stretch_line = 10; n = 0;
        do begin step(); n++; end while (!(drove_hs && dv == 11) && n < 6000);
        chk("stretch_seen", 32'(drove_hs && dv == 11), 1);
        step();
        chk("stretch_pre_locked", 32'(locked), 1);
        step();
        chk("stretch_locked_drop", 32'(locked), 0);
        chk("stretch_err", 32'(err_count), 1);
        chk("stretch_meas_hold", 32'(meas_h_total), 100);
        wait_vs(); vs_settle();
        chk("relock_a_no_sum", 32'(sum_valid), 0);
        wait_vs(); vs_settle();
        chk("relock_b_locked", 32'(locked), 0);
        wait_vs(); vs_settle();
        chk("relock_c_locked", 32'(locked), 1);

        // asynchronous reset mid-frame while locked
        repeat (1234) step();
        #2 reset_n = 1'b0;
        #1;
        chk("arst_outs_zero", 32'(|{meas_h_total, meas_h_active, meas_v_total, meas_v_active,
            locked, pix_valid, pix_x, pix_y, pix_rgb, frame_sum, sum_valid, err_count}), 0);
        chk("arst_err", 32'(err_count), 0);
        repeat (3) step();
        reset_n = 1'b1;
        wait_vs(); vs_settle();
        chk("rr1_locked", 32'(locked), 0);
        chk("rr1_no_sum", 32'(sum_valid), 0);
        wait_vs(); vs_settle();
        chk("rr2_locked", 32'(locked), 0);
        chk("rr2_frame_sum", 32'(frame_sum), 32'hFFF800);
        wait_vs(); step();
        chk("rr3_pre_locked", 32'(locked), 0);
        step();
        chk("rr3_locked", 32'(locked), 1);

        // hs lost while locked: saturation drops lock and counts one error
        idle = 1'b1;
        repeat (5000) step();
        chk("hs_loss_locked", 32'(locked), 0);
        chk("hs_loss_err", 32'(err_count), 1);
        chk("hs_loss_meas_hold", 32'(meas_h_total), 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
